// File: rtl/bg_attr_write_sched.sv
// Write scheduler for the background attribute table.
// Buffers CPU writes in a FIFO and runs a 1024-entry bulk clear.
// Table writes are only issued during blanking, because a table write
// suppresses the read port.
module bg_attr_write_sched #(
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          blank,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [4:0]    req_row,
    input  logic [4:0]    req_col,
    input  logic [7:0]    req_data,
    input  logic          clr_start,
    input  logic [7:0]    clr_data,
    output logic          clr_busy,
    output logic          tbl_we,
    output logic [4:0]    tbl_row,
    output logic [4:0]    tbl_col,
    output logic [7:0]    tbl_data,
    output logic [CW-1:0] fifo_count
);

    // state   | meaning
    // IDLE    | nothing queued, no clear running
    // DRAIN   | popping FIFO entries while blank is high
    // CLEAR   | bulk clear walking {row,col} from 0 to 1023
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t          state_q, state_d;
    logic [17:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      clr_addr_q;
    logic [7:0]      clr_fill_q;
    logic            busy_q, busy_d;
    logic            tbl_we_q;
    logic [4:0]      tbl_row_q, tbl_col_q;
    logic [7:0]      tbl_data_q;

    logic            push, pop, clr_accept, clr_issue, clr_last;
    logic [17:0]     head;

    // Issue decisions and next-state computation.
    always_comb begin
        req_ready  = (count_q != CW'(FIFO_DEPTH));
        push       = req_valid && req_ready;
        // A clear can only be started once the previous one has fully
        // retired, including the cycle its last write sits on tbl_*.
        clr_accept = clr_start && !busy_q;
        // The clear pre-empts draining: no pop in the accepting cycle.
        pop        = (state_q != ST_CLEAR) && (count_q != '0) && blank && !clr_accept;
        clr_issue  = (state_q == ST_CLEAR) && blank;
        clr_last   = clr_issue && (clr_addr_q == 10'h3FF);
        head       = mem_q[rd_ptr_q];

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DRAIN: begin
                if (clr_accept)          state_d = ST_CLEAR;
                else if (count_d != '0)  state_d = ST_DRAIN;
                else                     state_d = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_last)            state_d = ST_IDLE;
            end
            default:                     state_d = ST_IDLE;
        endcase

        // Busy stays up through the cycle the last clear write is presented.
        busy_d = (state_d == ST_CLEAR) || clr_last;
    end

    // FIFO storage; contents need no reset because pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_row, req_col, req_data};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Scheduler FSM with registered table-write outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            clr_addr_q <= '0;
            clr_fill_q <= '0;
            tbl_we_q   <= 1'b0;
            tbl_row_q  <= '0;
            tbl_col_q  <= '0;
            tbl_data_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            tbl_we_q <= pop || clr_issue;
            if (clr_accept) begin
                clr_fill_q <= clr_data;
                clr_addr_q <= '0;
            end else if (clr_issue) begin
                clr_addr_q <= clr_addr_q + 10'd1;
            end
            if (pop) begin
                tbl_row_q  <= head[17:13];
                tbl_col_q  <= head[12:8];
                tbl_data_q <= head[7:0];
            end else if (clr_issue) begin
                tbl_row_q  <= clr_addr_q[9:5];
                tbl_col_q  <= clr_addr_q[4:0];
                tbl_data_q <= clr_fill_q;
            end
        end
    end

    assign clr_busy   = busy_q;
    assign tbl_we     = tbl_we_q;
    assign tbl_row    = tbl_row_q;
    assign tbl_col    = tbl_col_q;
    assign tbl_data   = tbl_data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_bg_attr_write_sched.sv
// Scoreboard bench for bg_attr_write_sched: expected table writes are queued
// as stimulus is driven and checked in order as tbl_we pulses appear.
module tb_bg_attr_write_sched;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n, blank, req_valid, req_ready;
    logic [4:0]    req_row, req_col;
    logic [7:0]    req_data, clr_data;
    logic          clr_start, clr_busy, tbl_we;
    logic [4:0]    tbl_row, tbl_col;
    logic [7:0]    tbl_data;
    logic [CW-1:0] fifo_count;

    typedef struct packed {
        logic [4:0] row;
        logic [4:0] col;
        logic [7:0] data;
        logic       is_clr;
    } exp_t;

    exp_t exp_q[$];

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int wr_cnt  = 0;
    int clr_wr_cnt = 0;
    int run_len = 0;
    int last_wr_cyc = 0;
    logic blank_last = 1'b0;
    logic we_prev    = 1'b0;
    logic chk_drop   = 1'b0;

    bg_attr_write_sched #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .blank      (blank),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_row    (req_row),
        .req_col    (req_col),
        .req_data   (req_data),
        .clr_start  (clr_start),
        .clr_data   (clr_data),
        .clr_busy   (clr_busy),
        .tbl_we     (tbl_we),
        .tbl_row    (tbl_row),
        .tbl_col    (tbl_col),
        .tbl_data   (tbl_data),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle counter and the blank value the DUT sampled at each edge.
    always @(posedge clk) begin
        cyc++;
        blank_last = blank;
    end

    // Write monitor: every tbl_we pulse must match the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (chk_drop) begin
            chk("busy_drop", {31'd0, clr_busy}, 32'd0);
            chk_drop = 1'b0;
        end
        if (tbl_we) begin
            wr_cnt++;
            run_len = we_prev ? run_len + 1 : 1;
            last_wr_cyc = cyc;
            chk("blank_guard", {31'd0, blank_last}, 32'd1);
            if (exp_q.size() == 0) begin
                chk("spurious_wr", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_row",  {27'd0, tbl_row},  {27'd0, e.row});
                chk("wr_col",  {27'd0, tbl_col},  {27'd0, e.col});
                chk("wr_data", {24'd0, tbl_data}, {24'd0, e.data});
                if (e.is_clr) begin
                    clr_wr_cnt++;
                    if (e.row == 5'd31 && e.col == 5'd31) begin
                        chk("busy_last", {31'd0, clr_busy}, 32'd1);
                        chk_drop = 1'b1;
                    end
                end
            end
        end
        we_prev = tbl_we;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] r, input logic [4:0] c, input logic [7:0] d,
                        input bit enq, output bit acc);
        exp_t e;
        req_valid = 1'b1;
        req_row   = r;
        req_col   = c;
        req_data  = d;
        acc = req_ready;
        if (acc && enq) begin
            e = '{row: r, col: c, data: d, is_clr: 1'b0};
            exp_q.push_back(e);
        end
        tick();
        req_valid = 1'b0;
    endtask

    task automatic enq_entry(input logic [4:0] r, input logic [4:0] c, input logic [7:0] d);
        exp_t e;
        e = '{row: r, col: c, data: d, is_clr: 1'b0};
        exp_q.push_back(e);
    endtask

    task automatic enq_clear(input logic [7:0] fill);
        exp_t e;
        for (int i = 0; i < 1024; i++) begin
            e.row    = 5'(i >> 5);
            e.col    = 5'(i & 31);
            e.data   = fill;
            e.is_clr = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 32'd0);
    endtask

    initial begin
        bit acc;
        int c0, w0, nacc, n;
        logic [5:0] pat;

        rst_n = 1'b0; blank = 1'b0; req_valid = 1'b0;
        req_row = '0; req_col = '0; req_data = '0;
        clr_start = 1'b0; clr_data = '0;

        // Reset state
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("rst_we",    {31'd0, tbl_we},   32'd0);
            chk("rst_row",   {27'd0, tbl_row},  32'd0);
            chk("rst_col",   {27'd0, tbl_col},  32'd0);
            chk("rst_data",  {24'd0, tbl_data}, 32'd0);
            chk("rst_busy",  {31'd0, clr_busy}, 32'd0);
            chk("rst_count", 32'(fifo_count),   32'd0);
            chk("rst_ready", {31'd0, req_ready}, 32'd1);
        end
        rst_n = 1'b1;
        tick();

        // Single write, push-to-write latency of two cycles
        blank = 1'b1;
        w0 = wr_cnt;
        c0 = cyc;
        push(5'd3, 5'd7, 8'hA5, 1'b1, acc);
        wait_empty(10);
        repeat (3) tick();
        chk("single_lat", last_wr_cyc, c0 + 2);
        chk("single_cnt", wr_cnt - w0, 32'd1);

        // FIFO full with blank low, then drain back-to-back
        blank = 1'b0;
        w0 = wr_cnt;
        nacc = 0;
        for (int i = 0; i < 9; i++) begin
            push(5'(i), 5'(i + 1), 8'(8'h10 + i), 1'b1, acc);
            if (acc) nacc++;
        end
        chk("full_acc",   nacc, 32'd8);
        chk("full_ready", {31'd0, req_ready}, 32'd0);
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_nowr",  wr_cnt - w0, 32'd0);
        blank = 1'b1;
        wait_empty(20);
        tick();
        chk("full_run",   run_len, 32'd8);
        chk("full_empty", 32'(fifo_count), 32'd0);
        chk("full_ready2", {31'd0, req_ready}, 32'd1);

        // Blank gating
        blank = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 4; i++) push(5'(20 + i), 5'(2 * i), 8'(8'hC0 + i), 1'b1, acc);
        pat = 6'b110101;
        for (int k = 0; k < 6; k++) begin
            blank = pat[k];
            tick();
        end
        repeat (2) tick();
        chk("gate_left",  exp_q.size(), 32'd0);
        chk("gate_cnt",   wr_cnt - w0, 32'd4);
        chk("gate_count", 32'(fifo_count), 32'd0);

        // Full clear
        blank = 1'b1;
        clr_data = 8'h3C;
        clr_start = 1'b1;
        enq_clear(8'h3C);
        tick();
        clr_start = 1'b0;
        chk("clr_busy_up", {31'd0, clr_busy}, 32'd1);
        wait_empty(1100);
        repeat (2) tick();
        chk("clr_busy_end", {31'd0, clr_busy}, 32'd0);

        // Clear pre-empts drain; a second start during the clear is ignored
        blank = 1'b0;
        push(5'd1, 5'd2, 8'h11, 1'b0, acc);
        push(5'd4, 5'd5, 8'h22, 1'b0, acc);
        push(5'd6, 5'd8, 8'h33, 1'b0, acc);
        enq_entry(5'd1, 5'd2, 8'h11);
        blank = 1'b1;
        tick();
        clr_data = 8'h5A;
        clr_start = 1'b1;
        enq_clear(8'h5A);
        enq_entry(5'd4, 5'd5, 8'h22);
        enq_entry(5'd6, 5'd8, 8'h33);
        tick();
        clr_start = 1'b0;
        repeat (20) tick();
        chk("pre_held", 32'(fifo_count), 32'd2);
        push(5'd9, 5'd10, 8'h44, 1'b1, acc);
        chk("pre_acc", {31'd0, acc}, 32'd1);
        repeat (5) tick();
        clr_data = 8'h99;
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        wait_empty(1200);
        repeat (3) tick();
        chk("pre_empty", 32'(fifo_count), 32'd0);
        chk("pre_busy",  {31'd0, clr_busy}, 32'd0);

        // Reset in the middle of a clear
        clr_wr_cnt = 0;
        clr_data = 8'h77;
        clr_start = 1'b1;
        enq_clear(8'h77);
        tick();
        clr_start = 1'b0;
        n = 0;
        while (clr_wr_cnt < 100 && n < 200) begin
            tick();
            n++;
        end
        chk("mid_reached", clr_wr_cnt, 32'd100);
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        chk("mid_we",   {31'd0, tbl_we},   32'd0);
        chk("mid_busy", {31'd0, clr_busy}, 32'd0);
        rst_n = 1'b1;
        w0 = wr_cnt;
        repeat (50) tick();
        chk("mid_noresume", wr_cnt - w0, 32'd0);
        chk("mid_busy2", {31'd0, clr_busy}, 32'd0);
        chk("mid_count", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
